uart_rx_oversampled: RTL and testbench



---
 rtl/uart_rx_oversampled.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
// 8N1 UART receiver. The line goes through a 2-flop synchronizer and is sampled
// at 16x baud. Each bit is decided by a 2-of-3 vote at sample slots 7/8/9.
// Framing errors and overruns are flagged. A good byte is held until it is
// acknowledged.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit after the
// data bits and a parity_err output.
`timescale 1ns/1ps
module uart_rx_oversampled #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int OS_DIV    = CLK_FREQ / (BAUD_RATE * 16)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   input  logic       rx_ack,
   output logic       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       overrun
);

   localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [CW-1:0] OS_LAST = CW'(OS_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   logic          sync1_r;
   logic          rx_s;
   logic [CW-1:0] os_cnt_r;
   logic          tick_s;
   logic          vote_s;
   logic          start_s;
   logic [3:0]    samp_cnt_r;
   logic [2:0]    bit_cnt_r;
   logic          s7_r;
   logic          s8_r;
   logic [7:0]    shift_r;
   logic          deliver_r;
   state_t        state_r;
`ifdef UART_RX_PARITY_EN
   logic          parity_bad_r;
`endif

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

`ifdef UART_RX_PARITY_EN
   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   // Two-flop synchronizer for the asynchronous line. It resets to idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         sync1_r <= rx;
         rx_s    <= sync1_r;
      end
   end

   // Oversample tick strobe, mid-bit majority vote and start-edge detect.
   always_comb begin
      tick_s  = (os_cnt_r == OS_LAST);
      vote_s  = maj3(s7_r, s8_r, rx_s);
      start_s = (state_r == IDLE) && (rx_s == 1'b0);
   end

   // Free-running tick divider. It is re-phased on a start edge so that sampling is centred.
   always_ff @(posedge clk) begin
      if (rst) begin
         os_cnt_r <= CW'(0);
      end else if (start_s || tick_s) begin
         os_cnt_r <= CW'(0);
      end else begin
         os_cnt_r <= os_cnt_r + CW'(1);
      end
   end

   // Receive FSM plus the registered byte handshake and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         samp_cnt_r   <= 4'd0;
         bit_cnt_r    <= 3'd0;
         s7_r         <= 1'b1;
         s8_r         <= 1'b1;
         shift_r      <= 8'h00;
         deliver_r    <= 1'b0;
         rx_data      <= 8'h00;
         rx_ready     <= 1'b0;
         frame_err    <= 1'b0;
         overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err   <= 1'b0;
         parity_bad_r <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         deliver_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         // A new byte takes priority. A same-cycle ack lets it replace the held byte.
         if (deliver_r) begin
            if (!rx_ready || rx_ack) begin
               rx_data  <= shift_r;
               rx_ready <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_ready && rx_ack) begin
            rx_ready <= 1'b0;
         end

         if (tick_s && (state_r != IDLE) && (state_r != WAIT_HIGH)) begin
            samp_cnt_r <= samp_cnt_r + 4'd1;
            if (samp_cnt_r == 4'd7) s7_r <= rx_s;
            if (samp_cnt_r == 4'd8) s8_r <= rx_s;
         end

         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r    <= START;
                  samp_cnt_r <= 4'd0;
               end
            end
            START: begin
               if (tick_s) begin
                  if ((samp_cnt_r == 4'd9) && vote_s) begin
                     state_r    <= IDLE;
                     samp_cnt_r <= 4'd0;
                  end else if (samp_cnt_r == 4'd15) begin
                     state_r   <= DATA;
                     bit_cnt_r <= 3'd0;
                  end
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (samp_cnt_r == 4'd9) shift_r[bit_cnt_r] <= vote_s;
                  if (samp_cnt_r == 4'd15) begin
                     if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_r <= PARITY;
`else
                        state_r <= STOP;
`endif
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                     end
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick_s) begin
                  if (samp_cnt_r == 4'd9) begin
                     parity_bad_r <= (vote_s != even_par(shift_r));
                     parity_err   <= (vote_s != even_par(shift_r));
                  end
                  if (samp_cnt_r == 4'd15) state_r <= STOP;
               end
            end
`endif
            STOP: begin
               // Decide mid stop bit and return to IDLE early, so back-to-back frames resync.
               if (tick_s && (samp_cnt_r == 4'd9)) begin
                  samp_cnt_r <= 4'd0;
                  if (vote_s) begin
`ifdef UART_RX_PARITY_EN
                     deliver_r <= ~parity_bad_r;
`else
                     deliver_r <= 1'b1;
`endif
                     state_r <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state_r   <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: scoreboard bench for uart_rx_oversampled at OS_DIV=2
// (32 clocks per bit). Define UART_RX_PARITY_EN to also exercise the parity build.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
   localparam int BIT_CLKS = 32;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CLKS = NBITS * BIT_CLKS;
   // start edge -> rx_ready: 2 sync clocks + ((bits before stop)*16 + 10) ticks of 2 clocks
   localparam int LAT_NOM = 2 + ((NBITS - 1) * 16 + 10) * 2;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip;
   int         pe_cnt;
`endif

   int         total;
   int         bad;
   int         cyc;
   int         fe_cnt;
   int         ov_cnt;
   int         rise_cyc;
   int         start_cyc;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   logic       prev_ready;
   logic [7:0] prev_data;

   uart_rx_oversampled #(
      .CLK_FREQ  (3200000),
      .BAUD_RATE (100000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rx_ack     (rx_ack),
      .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: count error pulses and log every byte that lands in rx_data while ready.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (rst !== 1'b1) begin
         if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
         if (overrun === 1'b1) ov_cnt = ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
         if (parity_err === 1'b1) pe_cnt = pe_cnt + 1;
`endif
         if (rx_ready === 1'b1 && prev_ready !== 1'b1) begin
            obs_q.push_back(rx_data);
            rise_cyc = cyc;
         end else if (rx_ready === 1'b1 && rx_data !== prev_data) begin
            obs_q.push_back(rx_data);
         end
      end
      prev_ready = rx_ready;
      prev_data  = rx_data;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1, "watchdog expired");
   end

   // Drive one frame, LSB first. The caller is at a negedge, and rx is left at the stop value.
   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      start_cyc = cyc;
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^d) ^ par_flip;
      repeat (BIT_CLKS) @(negedge clk);
`endif
      rx = stop_v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   // Wait (bounded) for the next observed byte and pop it with its expected value.
   task automatic pop_pair(input int max_cyc, output bit found, output logic [7:0] e, output logic [7:0] o);
      found = 1'b0;
      e = 8'h00;
      o = 8'h00;
      for (int i = 0; i < max_cyc && !found; i++) begin
         if (obs_q.size() != 0 && exp_q.size() != 0) begin
            found = 1'b1;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx = 1'b1;
      rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", rx_ready); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      bit found;
      bit stable;
      logic [7:0] e, o;
      int lat;
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      pop_pair(64, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL basic_data: no byte got, want %h", 8'h41); end
      else if (o !== e) begin bad++; $display("FAIL basic_data: got %h want %h", o, e); end
      lat = rise_cyc - start_cyc;
      total++;
      if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
         bad++; $display("FAIL basic_latency: got %0d clocks want %0d +/-2", lat, LAT_NOM);
      end
      stable = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (rx_data !== 8'h41 || rx_ready !== 1'b1) stable = 1'b0;
      end
      total++; if (!stable) begin bad++; $display("FAIL basic_hold: data %h ready %b not held at 41/1", rx_data, rx_ready); end
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL basic_ack: ready got %b want 0", rx_ready); end
      do_ack();
      total++;
      if (rx_ready !== 1'b0 || rx_data !== 8'h41) begin
         bad++; $display("FAIL idle_ack_ignored: ready %b data %h want 0/41", rx_ready, rx_data);
      end
   endtask

   task automatic test_glitch();
      bit found;
      logic [7:0] e, o;
      int fe0;
      fe0 = fe_cnt;
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (400) @(negedge clk);
      total++;
      if (rx_ready !== 1'b0 || obs_q.size() != 0) begin
         bad++; $display("FAIL glitch_ready: ready %b bytes %0d want 0/0", rx_ready, obs_q.size());
      end
      total++; if (fe_cnt != fe0) begin bad++; $display("FAIL glitch_frame_err: pulses %0d want 0", fe_cnt - fe0); end
      exp_q.push_back(8'h35);
      send_frame(8'h35, 1'b1);
      pop_pair(64, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL glitch_next_data: no byte got, want 35"); end
      else if (o !== e) begin bad++; $display("FAIL glitch_next_data: got %h want %h", o, e); end
      do_ack();
   endtask

   task automatic test_frame_err();
      bit found;
      logic [7:0] e, o;
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0);
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL frame_err_pulse: pulses %0d want 1", fe_cnt - fe0); end
      total++;
      if (rx_ready !== 1'b0 || obs_q.size() != 0) begin
         bad++; $display("FAIL frame_err_discard: ready %b bytes %0d want 0/0", rx_ready, obs_q.size());
      end
      exp_q.push_back(8'h0A);
      send_frame(8'h0A, 1'b1);
      pop_pair(64, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL frame_err_next_data: no byte got, want 0a"); end
      else if (o !== e) begin bad++; $display("FAIL frame_err_next_data: got %h want %h", o, e); end
      do_ack();
   endtask

   task automatic test_overrun();
      bit found;
      logic [7:0] e, o;
      int ov0;
      ov0 = ov_cnt;
      exp_q.push_back(8'h31);
      send_frame(8'h31, 1'b1);
      send_frame(8'h0A, 1'b1);
      repeat (20) @(negedge clk);
      pop_pair(8, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL overrun_first: no byte got, want 31"); end
      else if (o !== e) begin bad++; $display("FAIL overrun_first: got %h want %h", o, e); end
      total++; if (ov_cnt - ov0 != 1) begin bad++; $display("FAIL overrun_pulse: pulses %0d want 1", ov_cnt - ov0); end
      total++;
      if (rx_data !== 8'h31 || rx_ready !== 1'b1 || obs_q.size() != 0) begin
         bad++; $display("FAIL overrun_keep: data %h ready %b extra %0d want 31/1/0", rx_data, rx_ready, obs_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      logic [7:0] e, o;
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midreset_data: got %h want 00", rx_data); end
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready: got %b want 0", rx_ready); end
      total++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("FAIL midreset_flags: frame_err %b overrun %b want 0/0", frame_err, overrun);
      end
      repeat (FRAME_CLKS) @(negedge clk);
      total++;
      if (rx_ready !== 1'b0 || obs_q.size() != 0) begin
         bad++; $display("FAIL midreset_partial: ready %b bytes %0d want 0/0", rx_ready, obs_q.size());
      end
      exp_q.push_back(8'h7A);
      send_frame(8'h7A, 1'b1);
      pop_pair(64, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL midreset_next_data: no byte got, want 7a"); end
      else if (o !== e) begin bad++; $display("FAIL midreset_next_data: got %h want %h", o, e); end
      do_ack();
   endtask

   task automatic test_back_to_back();
      bit found;
      bit seen;
      logic [7:0] e, o;
      int ov0;
      ov0 = ov_cnt;
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h0A);
      seen = 1'b0;
      fork
         begin
            send_frame(8'h31, 1'b1);
            send_frame(8'h0A, 1'b1);
         end
         begin
            for (int i = 0; i < FRAME_CLKS + 40 && !seen; i++) begin
               @(negedge clk);
               if (rx_ready === 1'b1) seen = 1'b1;
            end
            total++;
            if (!seen) begin
               bad++; $display("FAIL b2b_first_ready: ready never rose, want 1");
            end else begin
               // second byte arrives exactly one frame after the first
               repeat (FRAME_CLKS - 1) @(negedge clk);
               rx_ack = 1'b1;
               @(negedge clk);
               rx_ack = 1'b0;
               if (rx_ready !== 1'b1 || rx_data !== 8'h0A) begin
                  bad++; $display("FAIL b2b_coincident: ready %b data %h want 1/0a", rx_ready, rx_data);
               end
            end
         end
      join
      repeat (20) @(negedge clk);
      pop_pair(8, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL b2b_byte0: no byte got, want 31"); end
      else if (o !== e) begin bad++; $display("FAIL b2b_byte0: got %h want %h", o, e); end
      pop_pair(8, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL b2b_byte1: no byte got, want 0a"); end
      else if (o !== e) begin bad++; $display("FAIL b2b_byte1: got %h want %h", o, e); end
      total++; if (ov_cnt != ov0) begin bad++; $display("FAIL b2b_overrun: pulses %0d want 0", ov_cnt - ov0); end
      do_ack();
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      bit found;
      logic [7:0] e, o;
      int pe0, fe0;
      pe0 = pe_cnt;
      fe0 = fe_cnt;
      par_flip = 1'b1;
      send_frame(8'h03, 1'b1);
      par_flip = 1'b0;
      repeat (20) @(negedge clk);
      total++; if (pe_cnt - pe0 != 1) begin bad++; $display("FAIL parity_err_pulse: pulses %0d want 1", pe_cnt - pe0); end
      total++;
      if (rx_ready !== 1'b0 || obs_q.size() != 0) begin
         bad++; $display("FAIL parity_discard: ready %b bytes %0d want 0/0", rx_ready, obs_q.size());
      end
      total++; if (fe_cnt != fe0) begin bad++; $display("FAIL parity_frame_err: pulses %0d want 0", fe_cnt - fe0); end
      exp_q.push_back(8'h03);
      send_frame(8'h03, 1'b1);
      pop_pair(64, found, e, o);
      total++;
      if (!found) begin bad++; $display("FAIL parity_good_data: no byte got, want 03"); end
      else if (o !== e) begin bad++; $display("FAIL parity_good_data: got %h want %h", o, e); end
      total++; if (pe_cnt - pe0 != 1) begin bad++; $display("FAIL parity_good_pulse: pulses %0d want 1", pe_cnt - pe0); end
      do_ack();
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      fe_cnt = 0;
      ov_cnt = 0;
      rise_cyc = 0;
      start_cyc = 0;
      prev_ready = 1'b0;
      prev_data = 8'h00;
      rst = 1'b1;
      rx = 1'b1;
      rx_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
      pe_cnt = 0;
`endif
      @(negedge clk);
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
